// File: rtl/deserializer.sv
// ============================================================================
// Module   : deserializer
// Purpose  : Serial-to-parallel word collector with sync framing and a
//            single-entry valid/ready output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer #(
  parameter int LENGTH    = 24,
  parameter int MSB_FIRST = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_sync,
  input  logic              i_dout_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_frame_err
);

  localparam int              c_CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(LENGTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [LENGTH-1:0] r_sr;
  logic [LENGTH-1:0] r_dout;
  logic              r_valid;
  logic              r_overrun;
  logic              r_frame_err;

  logic [LENGTH-1:0] w_shifted;
  logic [LENGTH-1:0] w_first;
  logic              w_sync;
  logic              w_bit;
  logic              w_complete;

  // Bit 0 of a word must end up in bit 0 (LSB-first) or bit LENGTH-1 (MSB-first)
  generate
    if (MSB_FIRST == 0) begin : g_lsb_first
      assign w_shifted = {i_din, r_sr[LENGTH-1:1]};
      assign w_first   = {i_din, {(LENGTH-1){1'b0}}};
    end else begin : g_msb_first
      assign w_shifted = {r_sr[LENGTH-2:0], i_din};
      assign w_first   = {{(LENGTH-1){1'b0}}, i_din};
    end
  endgenerate

  assign w_sync     = i_en & i_sync;
  assign w_bit      = i_en & ~i_sync & (r_state == S_SHIFT);
  assign w_complete = w_bit & (r_cnt == c_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_sync) begin
        if (r_state == S_SHIFT) begin
          r_frame_err <= 1'b1;
        end
        r_sr    <= w_first;
        r_cnt   <= c_ONE;
        r_state <= S_SHIFT;
      end else if (w_bit) begin
        r_sr <= w_shifted;
        if (w_complete) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt + c_ONE;
        end
      end

      // A completing word may replace a buffered word only if it is accepted this edge
      if (w_complete) begin
        if (!r_valid || i_dout_ready) begin
          r_dout  <= w_shifted;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ov_dout      = r_dout;
  assign o_dout_valid = r_valid;
  assign o_busy       = (r_state == S_SHIFT);
  assign o_overrun    = r_overrun;
  assign o_frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_deserializer.sv
// ============================================================================
// Module   : tb_deserializer
// Purpose  : Directed self-checking bench for deserializer, LSB- and MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializer;

  localparam int LEN = 24;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           din;
  logic           sync;
  logic           ready;

  logic [LEN-1:0] dl_dout, dm_dout;
  logic           dl_valid, dm_valid;
  logic           dl_busy, dm_busy;
  logic           dl_ovr, dm_ovr;
  logic           dl_ferr, dm_ferr;

  int total = 0;
  int bad   = 0;
  int busy_cnt;
  int valid_cnt;

  // Behavioural model: a queue of received bits assembled into words
  bit             q[$];
  bit             m_busy;
  bit             m_valid;
  bit             m_ovr;
  bit             m_ferr;
  logic [LEN-1:0] m_dl;
  logic [LEN-1:0] m_dm;

  deserializer #(.LENGTH(LEN), .MSB_FIRST(0)) u_dut_lsb (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_din        (din),
    .i_sync       (sync),
    .i_dout_ready (ready),
    .ov_dout      (dl_dout),
    .o_dout_valid (dl_valid),
    .o_busy       (dl_busy),
    .o_overrun    (dl_ovr),
    .o_frame_err  (dl_ferr)
  );

  deserializer #(.LENGTH(LEN), .MSB_FIRST(1)) u_dut_msb (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_din        (din),
    .i_sync       (sync),
    .i_dout_ready (ready),
    .ov_dout      (dm_dout),
    .o_dout_valid (dm_valid),
    .o_busy       (dm_busy),
    .o_overrun    (dm_ovr),
    .o_frame_err  (dm_ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit done;
    logic [LEN-1:0] wl, wm;
    done = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_busy = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
      m_dl = '0;  m_dm = '0;
    end else begin
      if (en && sync) begin
        if (m_busy) m_ferr = 1;
        q.delete();
        q.push_back(din);
        m_busy = 1;
      end else if (en && m_busy) begin
        q.push_back(din);
        if (q.size() == LEN) begin
          for (int i = 0; i < LEN; i++) begin
            wl[i]         = q[i];
            wm[LEN-1-i]   = q[i];
          end
          q.delete();
          m_busy = 0;
          done   = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || ready) begin
          m_valid = 1; m_dl = wl; m_dm = wm;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid_lsb", {31'd0, dl_valid}, {31'd0, m_valid});
    chk("valid_msb", {31'd0, dm_valid}, {31'd0, m_valid});
    chk("dout_lsb",  {8'd0, dl_dout},   {8'd0, m_dl});
    chk("dout_msb",  {8'd0, dm_dout},   {8'd0, m_dm});
    chk("busy_lsb",  {31'd0, dl_busy},  {31'd0, m_busy});
    chk("busy_msb",  {31'd0, dm_busy},  {31'd0, m_busy});
    chk("ovr_lsb",   {31'd0, dl_ovr},   {31'd0, m_ovr});
    chk("ovr_msb",   {31'd0, dm_ovr},   {31'd0, m_ovr});
    chk("ferr_lsb",  {31'd0, dl_ferr},  {31'd0, m_ferr});
    chk("ferr_msb",  {31'd0, dm_ferr},  {31'd0, m_ferr});
  endtask

  task automatic tick(input logic e, input logic d, input logic s);
    en = e; din = d; sync = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (dl_busy)  busy_cnt++;
    if (dl_valid) valid_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [LEN-1:0] w, input bit msb, input bit gap, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? w[LEN-1-i] : w[i];
      tick(1'b1, b, (i == 0));
      // Disabled cycles carry sync=1 to prove they are ignored
      if (gap && i < nbits - 1) tick(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    logic [LEN-1:0] w;
    rst_n = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0; ready = 1'b0;
    busy_cnt = 0; valid_cnt = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_dout",  {8'd0, dl_dout}, 32'h0);
    chk("rst_valid", {31'd0, dl_valid}, 32'h0);
    chk("rst_busy",  {31'd0, dl_busy}, 32'h0);

    // Nominal LSB-first
    ready = 1'b1;
    busy_cnt = 0;
    send_word(24'hA5C30F, 0, 0, LEN);
    chk("nom_dout",  {8'd0, dl_dout}, 32'h00A5C30F);
    chk("nom_valid", {31'd0, dl_valid}, 32'h1);
    chk("nom_busy_cycles", busy_cnt, 32'd23);
    chk("nom_flags", {30'd0, dl_ovr, dl_ferr}, 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    chk("nom_accept", {31'd0, dl_valid}, 32'h0);

    // Gapped strobe, MSB-first instance
    send_word(24'h123456, 1, 1, LEN);
    chk("gap_dout_msb", {8'd0, dm_dout}, 32'h00123456);
    chk("gap_valid", {31'd0, dm_valid}, 32'h1);
    chk("gap_ferr", {31'd0, dm_ferr}, 32'h0);
    tick(1'b0, 1'b0, 1'b0);

    // Back-to-back with backpressure
    ready = 1'b0;
    send_word(24'h000001, 0, 0, LEN);
    chk("bp_first", {8'd0, dl_dout}, 32'h00000001);
    send_word(24'hFFFFFE, 0, 0, LEN);
    chk("bp_hold_dout", {8'd0, dl_dout}, 32'h00000001);
    chk("bp_valid", {31'd0, dl_valid}, 32'h1);
    chk("bp_overrun", {31'd0, dl_ovr}, 32'h1);
    ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("bp_drain", {31'd0, dl_valid}, 32'h0);

    // Completion and accept on the same edge
    do_reset();
    ready = 1'b0;
    send_word(24'h111111, 0, 0, LEN);
    chk("same_first", {8'd0, dl_dout}, 32'h00111111);
    w = 24'h222222;
    send_word(w, 0, 0, LEN - 1);
    ready = 1'b1;
    tick(1'b1, w[LEN-1], 1'b0);
    chk("same_dout",  {8'd0, dl_dout}, 32'h00222222);
    chk("same_valid", {31'd0, dl_valid}, 32'h1);
    chk("same_ovr",   {31'd0, dl_ovr}, 32'h0);
    tick(1'b0, 1'b0, 1'b0);

    // Mid-word resync
    do_reset();
    ready = 1'b1;
    valid_cnt = 0;
    send_word(24'hABCDEF, 0, 0, 10);
    send_word(24'h0F0F0F, 0, 0, LEN);
    chk("resync_ferr", {31'd0, dl_ferr}, 32'h1);
    chk("resync_dout", {8'd0, dl_dout}, 32'h000F0F0F);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("resync_words", valid_cnt, 32'd1);

    // Reset mid-word with data pending
    do_reset();
    ready = 1'b0;
    send_word(24'h333333, 0, 0, LEN);
    chk("rmw_pending", {31'd0, dl_valid}, 32'h1);
    send_word(24'h444444, 0, 0, 12);
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("rmw_zero", {8'd0, dl_dout, dl_valid, dl_busy, dl_ovr, dl_ferr}, 32'h0);
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    chk("rmw_ignored", busy_cnt, 32'd0);
    ready = 1'b1;
    send_word(24'h0A0B0C, 0, 0, LEN);
    chk("rmw_recover", {8'd0, dl_dout}, 32'h000A0B0C);
    tick(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Serial-to-parallel converter for the FIR filter sample path; the receive-side counterpart of the parallel-to-serial stage.
- Collects LENGTH serial bits into a word, framed by a start-of-word sync strobe, and presents the word on a valid/ready output buffer.
- Bit order defaults to LSB-first, matching the existing serializer's shift-right output.

Parameters:
- LENGTH, 24, word width in bits; must be >= 2.
- MSB_FIRST, 0, 0 = first received bit lands in bit 0; 1 = first received bit lands in bit LENGTH-1.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_en  input  1  bit strobe; i_din and i_sync are sampled only on cycles with i_en=1.
- i_din  input  1  serial data bit.
- i_sync  input  1  marks the current i_din as bit 0 of a new word; qualified by i_en.
- i_dout_ready  input  1  downstream accepts ov_dout when high together with o_dout_valid.
- ov_dout  output  LENGTH  assembled parallel word; held stable while o_dout_valid=1.
- o_dout_valid  output  1  ov_dout holds an unaccepted word.
- o_busy  output  1  high while a word is partially collected (state S_SHIFT).
- o_overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- o_frame_err  output  1  sticky: i_sync arrived before the current word completed.

Behaviour:
- Reset (i_rst_n=0 at clock edge):
  - state=S_IDLE.
  - Shift register, bit counter, ov_dout, o_dout_valid, o_busy, o_overrun and o_frame_err all go to 0.
  - Reset applied mid-word discards the partial word and any buffered word.
- Bit counter width is $clog2(LENGTH).
- Shift register is LENGTH bits.
  - MSB_FIRST=0: a new bit enters at bit LENGTH-1 and the register shifts right.
  - MSB_FIRST=1: a new bit enters at bit 0 and the register shifts left.
- i_en=0: state, counter, shift register and all outputs hold. Exception: the output handshake (i_dout_ready) is still honoured.
- State S_IDLE:
  - i_en=1, i_sync=1: capture i_din as bit 0, counter=1, go to S_SHIFT.
  - i_en=1, i_sync=0: bit ignored.
- State S_SHIFT:
  - i_en=1, i_sync=0: shift in i_din, counter+1.
  - When the captured bit is bit LENGTH-1 (counter==LENGTH-1 before increment), the word is complete. Go to S_IDLE, counter=0.
- Sync inside S_SHIFT (i_en=1, i_sync=1 before the word completes):
  - Partial word discarded.
  - o_frame_err<=1.
  - i_din captured as bit 0 of the new word, counter=1, stay in S_SHIFT.
- Word completion with S_IDLE requiring a fresh i_sync:
  - LENGTH=1-cycle-per-bit back-to-back words are supported, provided each word's first bit carries i_sync.
- Output buffer on the completion edge:
  - o_dout_valid=0, or (o_dout_valid=1 and i_dout_ready=1): ov_dout<=completed word, o_dout_valid<=1 on the same edge. Latency is 1 cycle from the last bit's sampling edge.
  - o_dout_valid=1 and i_dout_ready=0: word dropped, ov_dout unchanged, o_overrun<=1.
- Handshake:
  - o_dout_valid=1, i_dout_ready=1, no completion on that edge: o_dout_valid<=0; ov_dout retains its value.
  - ov_dout must not change while o_dout_valid=1 and i_dout_ready=0.
- Sticky flags: o_overrun and o_frame_err are cleared only by reset.
- o_busy is 1 exactly when state==S_SHIFT.

Test Plan:
- Nominal LSB-first (LENGTH=24): reset, hold i_dout_ready=1, send 0xA5C30F LSB-first with i_en=1 every cycle and i_sync on the first bit.
  - Required: ov_dout=0xA5C30F and o_dout_valid=1 on the cycle after the 24th bit; o_busy high for 23 cycles; flags stay 0.
- Gapped strobe and MSB_FIRST=1: send 0x123456 MSB-first with i_en toggling 1,0,1,0.
  - Required: ov_dout=0x123456 one cycle after the last enabled bit; no state change on i_en=0 cycles.
- Back-to-back with backpressure: send 0x000001, then 0xFFFFFE, with i_dout_ready=0 throughout.
  - Required: ov_dout stays 0x000001, o_dout_valid=1, o_overrun=1 after the second word.
  - Then pulse i_dout_ready: o_dout_valid falls to 0.
- Completion and accept on the same edge: o_dout_valid=1 holding 0x111111; assert i_dout_ready on the completion edge of 0x222222.
  - Required: ov_dout=0x222222, o_dout_valid stays 1, o_overrun stays 0.
- Mid-word resync: assert i_sync at bit 10 of a word, then send 24 bits of 0x0F0F0F.
  - Required: o_frame_err=1; ov_dout=0x0F0F0F; exactly one valid word.
- Reset mid-word and with data pending: drive i_rst_n=0 for 1 cycle at bit 12 while o_dout_valid=1.
  - Required: next cycle all outputs are 0 and state is idle.
  - Non-sync bits that follow are ignored until the next i_sync.
